// File: rtl/p2s_rr_scheduler.sv
// Purpose : round-robin arbiter sharing one W-bit parallel-to-serial shifter among N_REQ requesters.
// Latency : word captured at grant edge E0; bit W-1-k is on dout in the cycle after edge E0+k.
// Backpressure: none downstream; requesters hold req/d until they see gnt, and wait while busy.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req[N_REQ]      level-sensitive requests, sampled only at arbitration edges
//   d[N_REQ*W]      packed words, requester i owns d[i*W +: W]
//   gnt[N_REQ]      one-hot grant pulse, high during the first bit cycle of a word
//   dout            serial data, MSB first
//   dout_valid      dout carries a valid bit
//   last            final (LSB) bit of the word is on dout
//   src_id          requester whose word is on dout
//   busy            shifter occupied (mirrors dout_valid)
module p2s_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] d,
    output logic [N_REQ-1:0]   gnt,
    output logic               dout,
    output logic               dout_valid,
    output logic               last,
    output logic [ID_W-1:0]    src_id,
    output logic               busy
);

    localparam int CNT_W = $clog2(W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     sreg;
    logic [W-1:0]     win_word;
    logic [N_REQ-1:0] gnt_nxt;
    logic             any_req;
    logic             word_done;
    logic             arb;

    // Winner search starting at ptr. Scanning offsets from the far end down
    // lets the nearest requesting offset overwrite any farther one.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                win     = ID_W'((int'(ptr) + k) % N_REQ);
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        win_word = '0;
        gnt_nxt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win) begin
                win_word   = d[i*W +: W];
                gnt_nxt[i] = 1'b1;
            end
        end
    end

    assign ptr_nxt   = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    assign word_done = (state == SHIFT) && (cnt == CNT_W'(W - 1));
    // Arbitration happens in IDLE and on the edge retiring the last bit,
    // which is what gives back-to-back words with no bubble.
    assign arb       = (state == IDLE) || word_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = SHIFT;
            SHIFT: if (word_done) state_nxt = any_req ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            cnt        <= '0;
            sreg       <= '0;
            gnt        <= '0;
            dout_valid <= 1'b0;
            last       <= 1'b0;
            src_id     <= '0;
        end else if (arb) begin
            cnt  <= '0;
            last <= 1'b0;
            if (any_req) begin
                sreg       <= win_word;
                gnt        <= gnt_nxt;
                dout_valid <= 1'b1;
                src_id     <= win;
                ptr        <= ptr_nxt;
            end else begin
                sreg       <= '0;
                gnt        <= '0;
                dout_valid <= 1'b0;
                src_id     <= '0;
            end
        end else begin
            // Mid-word: advance to the next bit; last flags the LSB cycle.
            sreg <= sreg << 1;
            cnt  <= cnt + 1'b1;
            last <= (cnt == CNT_W'(W - 2));
            gnt  <= '0;
        end
    end

    // sreg is cleared whenever the shifter is idle, so its MSB is the registered dout.
    assign dout = sreg[W-1];
    assign busy = dout_valid;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// Purpose : directed stimulus with a cycle-stamped scoreboard for p2s_rr_scheduler.
// Latency : each expected beat carries the cycle it must appear in.
// Backpressure: n/a; requests are driven and released on negative clock edges.
module tb_p2s_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] d;
    logic [3:0]  gnt;
    logic        dout;
    logic        dout_valid;
    logic        last;
    logic [1:0]  src_id;
    logic        busy;

    p2s_rr_scheduler #(.N_REQ(4), .W(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .d          (d),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last),
        .src_id     (src_id),
        .busy       (busy)
    );

    typedef struct {
        int         cyc;
        logic       dout;
        logic       last;
        logic [1:0] id;
        logic       g;
    } beat_t;

    beat_t sb[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    e;
    beat_t mb;
    logic [3:0] exp_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic push_beats(input int e0, input logic [3:0] w, input int id, input int nb);
        beat_t b;
        for (int k = 0; k < nb; k++) begin
            b.cyc  = e0 + k;
            b.dout = w[3-k];
            b.last = (k == 3);
            b.id   = 2'(id);
            b.g    = (k == 0);
            sb.push_back(b);
        end
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if ({gnt, dout, dout_valid, last, src_id, busy} !== 10'b0) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b dout=%b vld=%b last=%b id=%0d busy=%b, expected all 0",
                     name, gnt, dout, dout_valid, last, src_id, busy);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain_and_reset();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected beats never seen, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_between_tests");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle out of reset, either a valid beat matches the head
    // of the scoreboard at its stamped cycle, or all outputs are idle-zero.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed_beat: no valid output at cycle %0d, expected id=%0d dout=%b",
                         sb[0].cyc, sb[0].id, sb[0].dout);
                void'(sb.pop_front());
            end
            if (dout_valid) begin
                n_chk++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_beat at cycle %0d: got id=%0d dout=%b gnt=%b, expected no valid",
                             cyc, src_id, dout, gnt);
                end else begin
                    mb = sb.pop_front();
                    exp_gnt = mb.g ? (4'b0001 << mb.id) : 4'b0000;
                    if ({dout, last, src_id, gnt, busy} !== {mb.dout, mb.last, mb.id, exp_gnt, 1'b1}) begin
                        n_fail++;
                        $display("FAIL beat cycle %0d: got dout=%b last=%b id=%0d gnt=%b busy=%b, expected dout=%b last=%b id=%0d gnt=%b busy=1",
                                 cyc, dout, last, src_id, gnt, busy, mb.dout, mb.last, mb.id, exp_gnt);
                    end
                end
            end else begin
                n_chk++;
                if ({gnt, dout, last, src_id, busy} !== 9'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs cycle %0d: got gnt=%b dout=%b last=%b id=%0d busy=%b, expected all 0",
                             cyc, gnt, dout, last, src_id, busy);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        d     = 16'b0;
        #3 check_zero("reset_state");
        #10;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 1011 from requester 0, then idle.
        @(negedge clk);
        e = cyc + 1;
        d[3:0] = 4'b1011;
        req = 4'b0001;
        push_beats(e, 4'b1011, 0, 4);
        @(negedge clk);
        req = 4'b0000;
        wait_cyc(e + 8);
        drain_and_reset();

        // All requesting: grants 0,1,2,3,0 back to back, 20 valid cycles.
        @(negedge clk);
        e = cyc + 1;
        d = {4'b0011, 4'b1110, 4'b0110, 4'b1001};
        req = 4'b1111;
        push_beats(e,      4'b1001, 0, 4);
        push_beats(e + 4,  4'b0110, 1, 4);
        push_beats(e + 8,  4'b1110, 2, 4);
        push_beats(e + 12, 4'b0011, 3, 4);
        push_beats(e + 16, 4'b1001, 0, 4);
        wait_cyc(e + 19);
        req = 4'b0000;
        wait_cyc(e + 24);
        drain_and_reset();

        // Fairness: req=0101 alternates 0,2,0,2.
        @(negedge clk);
        e = cyc + 1;
        d = {4'b0000, 4'b0110, 4'b0000, 4'b1010};
        req = 4'b0101;
        push_beats(e,      4'b1010, 0, 4);
        push_beats(e + 4,  4'b0110, 2, 4);
        push_beats(e + 8,  4'b1010, 0, 4);
        push_beats(e + 12, 4'b0110, 2, 4);
        wait_cyc(e + 15);
        req = 4'b0000;
        wait_cyc(e + 20);
        drain_and_reset();

        // Back-to-back: requester 1 arrives mid-word, stream 1,1,0,0,0,0,1,1.
        @(negedge clk);
        e = cyc + 1;
        d = {4'b0000, 4'b0000, 4'b0000, 4'b1100};
        req = 4'b0001;
        push_beats(e,     4'b1100, 0, 4);
        push_beats(e + 4, 4'b0011, 1, 4);
        @(negedge clk);
        req = 4'b0000;
        wait_cyc(e + 1);
        d[7:4] = 4'b0011;
        req = 4'b0010;
        wait_cyc(e + 4);
        req = 4'b0000;
        wait_cyc(e + 10);
        drain_and_reset();

        // Reset mid-word after 2 bits, then req=1010 grants 1 first.
        @(negedge clk);
        e = cyc + 1;
        d = {4'b0000, 4'b0000, 4'b0000, 4'b1011};
        req = 4'b0001;
        push_beats(e, 4'b1011, 0, 2);
        @(negedge clk);
        req = 4'b0000;
        wait_cyc(e + 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_midword");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = cyc + 1;
        d = {4'b1001, 4'b0000, 4'b0101, 4'b0000};
        req = 4'b1010;
        push_beats(e,     4'b0101, 1, 4);
        push_beats(e + 4, 4'b1001, 3, 4);
        wait_cyc(e + 7);
        req = 4'b0000;
        wait_cyc(e + 12);
        drain_and_reset();

        // Transient req[3] for 2 cycles mid-word: never granted.
        @(negedge clk);
        e = cyc + 1;
        d = {4'b1111, 4'b0000, 4'b0000, 4'b0110};
        req = 4'b0001;
        push_beats(e, 4'b0110, 0, 4);
        @(negedge clk);
        req = 4'b0000;
        wait_cyc(e + 1);
        req = 4'b1000;
        wait_cyc(e + 3);
        req = 4'b0000;
        wait_cyc(e + 12);
        drain_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/p2s_rr_scheduler.md
# p2s_rr_scheduler

Round-robin scheduler that shares one 4-bit parallel-to-serial shifter among several requesters. Each requester presents a parallel word and a request. The block grants one requester at a time, captures its word, and shifts the word out MSB first with per-bit valid, end-of-word and source-ID tags. It sits between the per-channel word producers and the single serial output lane.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 4, word width in bits (2..16)
- ID_W, 2, width of src_id (clog2(N_REQ), minimum 1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request, level-sensitive
- d  input  N_REQ*W  packed words; requester i owns d[i*W +: W]
- gnt  output  N_REQ  one-hot grant pulse, registered; high one cycle when word i is captured
- dout  output  1  serial data, registered
- dout_valid  output  1  dout carries a valid bit
- last  output  1  marks the final (LSB) bit of a word
- src_id  output  ID_W  index of the requester whose word is on dout
- busy  output  1  shifter occupied (state SHIFT)

One clock. Reset is asynchronous and active-low (clk, rst_n).

## Operation
- States: IDLE, SHIFT.
- Round-robin pointer ptr:
  - Search order is ptr, ptr+1, …, wrapping mod N_REQ.
  - After a grant to i, ptr = (i+1) mod N_REQ.
  - Reset value of ptr is 0.
- IDLE, at a clock edge with any req bit high:
  - Pick winner i.
  - Load the shift register from d[i], set gnt[i]=1 and src_id=i.
  - Drive dout=d[i][W-1] and dout_valid=1.
  - Clear bit counter to 0; go to SHIFT.
- IDLE with no req: all outputs are 0.
- SHIFT, each edge:
  - Shift the register left; dout = next bit; increment the counter.
  - gnt returns to 0 on the edge after the grant.
  - last=1 while the counter is W-1 (bit 0 on dout).
- SHIFT, edge that ends the last bit:
  - If any req is high, arbitrate and load immediately (same actions as IDLE). This gives zero bubble.
  - Otherwise go to IDLE and clear dout, dout_valid, last, src_id and busy.
- req is sampled only at arbitration edges. Requests raised and dropped during SHIFT are never granted.
- Requesters must hold d[i] stable while req[i] is high. They drop req[i] after sampling gnt[i]=1, or keep it high to queue another word. A re-request is granted again only after the other pending requesters, by the pointer rule.
- The word is captured at the grant edge. Changes to d after the grant do not affect the word in flight.

## Timing
- Latency: word captured at edge E0. Bit W-1-k is on dout during the cycle after edge E0+k, for k=0..W-1.
- A granted word occupies exactly W cycles.
- Sustained throughput: 1 bit per cycle with dout_valid continuously high while requests remain.
- busy equals dout_valid.
- gnt is high exactly in the first bit cycle of each word, with one bit set.
- Reset values: gnt=0, dout=0, dout_valid=0, last=0, src_id=0, busy=0, state=IDLE, ptr=0, counter=0.
- Reset asserted mid-word: all outputs go to reset values immediately (asynchronous) and the word is discarded. After rst_n deasserts, the first grant follows the pointer from 0.
- Simultaneous last-bit and new requests: the new grant takes effect on the same edge that retires the last bit. No idle cycle is inserted.

## Test plan
- Single request, N_REQ=4, W=4: req=0001 with d0=4'b1011.
  - gnt=0001 for 1 cycle.
  - dout=1,0,1,1 on 4 consecutive cycles, dout_valid=1, src_id=0, last only on the 4th cycle.
  - Then IDLE with all outputs 0.
- All requesting: req=1111 held, d0..d3 distinct.
  - Grants go 0,1,2,3,0 at 4-cycle spacing.
  - dout_valid stays high for 20 cycles with no gap.
  - src_id follows the grant order.
- Fairness: req=0101 held after reset. Grants alternate 0,2,0,2, and src_id matches.
- Back-to-back: requester 1 raises req during requester 0's word 4'b1100, with d1=4'b0011.
  - Serial stream is 1,1,0,0,0,0,1,1 with dout_valid high for 8 cycles.
  - gnt[1] pulses in cycle 5.
- Reset mid-word: assert rst_n=0 after 2 bits.
  - Outputs become 0 without waiting for a clock edge.
  - After release, with req=1010, requester 1 is granted first (ptr=0 search).
- Transient request: req[3] pulses for 2 cycles in the middle of a word, then drops.
  - No gnt[3] occurs; the block returns to IDLE after the current word.
